// File: rtl/prog_sequencer.sv
// prog_sequencer: single-clock fetch/issue controller between ROM and CPU.
// Define SEQ_STEP_EN to add single-step ports (step_mode, step) and PAUSE.
module prog_sequencer #(
  parameter int AW        = 5,
  parameter int DW        = 9,
  parameter int LAST_ADDR = 31,
  parameter int ROM_LAT   = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          stop,
  input  logic [DW-1:0] rom_data,
  input  logic          done,
`ifdef SEQ_STEP_EN
  input  logic          step_mode,
  input  logic          step,
`endif
  output logic [AW-1:0] addr,
  output logic          run,
  output logic [DW-1:0] din,
  output logic          busy,
  output logic          halted,
  output logic          err,
  output logic [7:0]    icount
);

  localparam int CMAX =
    (ROM_LAT > TIMEOUT) ? ROM_LAT : TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [AW-1:0] LAST = AW'(LAST_ADDR);
  localparam logic [CW-1:0] LAT_END = CW'(ROM_LAT);
  localparam logic [CW-1:0] WD_END = CW'(TIMEOUT - 1);
  localparam logic [2:0] OP_MVI = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_I,
    S_FETCH_D,
    S_ISSUE,
    S_EXEC,
`ifdef SEQ_STEP_EN
    S_PAUSE,
`endif
    S_HALT
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_pc;
  logic [DW-1:0]   r_ir;
  logic [DW-1:0]   r_imm;
  logic [CW-1:0]   r_cnt;
  logic            r_stop_pend;

  logic            w_busy;
  logic            w_ir_mvi;
  logic            w_rd_mvi;
  logic            w_lat_done;
  logic            w_wd_hit;
  logic            w_stop_any;
  logic [AW-1:0]   w_pc_p1;
  logic [AW-1:0]   w_pc_p2;
  logic [AW-1:0]   w_pc_nxt;

  assign w_busy = (r_state == S_FETCH_I) ||
                  (r_state == S_FETCH_D) ||
                  (r_state == S_ISSUE)   ||
                  (r_state == S_EXEC);
  assign busy   = w_busy;
  assign halted = (r_state == S_HALT);

  assign w_ir_mvi   = (r_ir[DW-1:DW-3] == OP_MVI);
  assign w_rd_mvi   = (rom_data[DW-1:DW-3] == OP_MVI);
  assign w_lat_done = (r_cnt == LAT_END);
  assign w_wd_hit   = (r_cnt == WD_END);
  assign w_stop_any = stop | r_stop_pend;

  // Wrap-aware +1/+2 so an mvi at LAST takes its immediate from 0.
  assign w_pc_p1  = (r_pc == LAST) ? '0 : r_pc + 1'b1;
  assign w_pc_p2  = (w_pc_p1 == LAST) ? '0 : w_pc_p1 + 1'b1;
  assign w_pc_nxt = w_ir_mvi ? w_pc_p2 : w_pc_p1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_ir        <= '0;
      r_imm       <= '0;
      r_cnt       <= '0;
      r_stop_pend <= 1'b0;
      addr        <= '0;
      run         <= 1'b0;
      din         <= '0;
      err         <= 1'b0;
      icount      <= '0;
    end else begin
      run <= 1'b0;
      if (w_busy && stop) r_stop_pend <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (stop) begin
            r_state <= S_HALT;
          end else if (start) begin
            r_state <= S_FETCH_I;
            r_cnt   <= '0;
          end
        end
        S_HALT: begin
          if (start && !stop) begin
            err         <= 1'b0;
            r_stop_pend <= 1'b0;
            r_state     <= S_FETCH_I;
            r_cnt       <= '0;
          end
        end
        S_FETCH_I: begin
          if (w_lat_done) begin
            r_ir  <= rom_data;
            r_cnt <= '0;
            if (w_rd_mvi) begin
              r_state <= S_FETCH_D;
              addr    <= w_pc_p1;
            end else begin
              r_state <= S_ISSUE;
              run     <= 1'b1;
              din     <= rom_data;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FETCH_D: begin
          if (w_lat_done) begin
            r_imm   <= rom_data;
            r_cnt   <= '0;
            addr    <= r_pc;
            r_state <= S_ISSUE;
            run     <= 1'b1;
            din     <= r_ir;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          r_state <= S_EXEC;
          r_cnt   <= '0;
          din     <= w_ir_mvi ? r_imm : r_ir;
        end
        S_EXEC: begin
          if (done) begin
            r_pc   <= w_pc_nxt;
            addr   <= w_pc_nxt;
            icount <= icount + 8'd1;
            r_cnt  <= '0;
            if (w_stop_any) begin
              r_state     <= S_HALT;
              r_stop_pend <= 1'b0;
            end
`ifdef SEQ_STEP_EN
            else if (step_mode) begin
              r_state <= S_PAUSE;
            end
`endif
            else begin
              r_state <= S_FETCH_I;
            end
          end else if (w_wd_hit) begin
            err         <= 1'b1;
            r_state     <= S_HALT;
            r_stop_pend <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef SEQ_STEP_EN
        S_PAUSE: begin
          if (stop) begin
            r_state <= S_HALT;
          end else if (step) begin
            r_state <= S_FETCH_I;
            r_cnt   <= '0;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: vector table plus issue scoreboard for prog_sequencer.
// Sync-ROM model (latency 1) and a CPU model that answers run with done.
`timescale 1ns/1ps
module tb_prog_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       done = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic [8:0] rom_data = '0;
  logic [4:0] addr;
  logic       run;
  logic [8:0] din;
  logic       busy;
  logic       halted;
  logic       err;
  logic [7:0] icount;

  logic [8:0] rom [32];
  int         checks = 0;
  int         failures = 0;
  int         dly = 2;
  logic       done_en = 1'b1;
  int         dcnt = 0;

  typedef struct {
    logic [4:0] a;
    logic [8:0] d;
  } sb_t;
  sb_t q[$];
  sb_t e_mon;

  typedef struct {
    logic [8:0] ir;
    logic [8:0] imm;
    int         lat;
    logic [4:0] pc;
    logic [8:0] xdin;
  } vec_t;
  vec_t vt[5];

  prog_sequencer dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .stop     (stop),
    .rom_data (rom_data),
    .done     (done),
`ifdef SEQ_STEP_EN
    .step_mode(step_mode),
    .step     (step),
`endif
    .addr     (addr),
    .run      (run),
    .din      (din),
    .busy     (busy),
    .halted   (halted),
    .err      (err),
    .icount   (icount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[addr];

  // CPU model: done high for one cycle, dly cycles after the run cycle
  always @(negedge clk) begin
    if (!resetn) begin
      dcnt = 0;
      done = 1'b0;
    end else if (run) begin
      dcnt = dly;
      done = 1'b0;
    end else if (dcnt > 0) begin
      dcnt = dcnt - 1;
      done = done_en && (dcnt == 0);
    end else begin
      done = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && run) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_run", 32'(addr), 32'hFFFF_FFFF);
      end else begin
        e_mon = q.pop_front();
        chk("sb_addr", 32'(addr), 32'(e_mon.a));
        chk("sb_din", 32'(din), 32'(e_mon.d));
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 9'h000;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    q.delete();
    resetn = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_run(output int n);
    n = 1;
    while (!run && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!run) chk("run_timeout", 32'(run), 32'd1);
  endtask

  task automatic wait_halt();
    int n = 0;
    while (!halted && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!halted) chk("halt_timeout", 32'(halted), 32'd1);
  endtask

  task automatic stop_halt();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_halt();
  endtask

  initial begin
    int   n;
    logic seen31;
    logic f0;

    vt[0] = '{9'h00A, 9'h1FF, 3, 5'd1, 9'h00A};
    vt[1] = '{9'h058, 9'h0A5, 5, 5'd2, 9'h0A5};
    vt[2] = '{9'h1FF, 9'h001, 3, 5'd1, 9'h1FF};
    vt[3] = '{9'h07F, 9'h100, 5, 5'd2, 9'h100};
    vt[4] = '{9'h081, 9'h000, 3, 5'd1, 9'h081};

    clear_rom();
    do_reset();
    chk("reset_state",
        32'({addr, run, din, busy, halted, err, icount}), 32'd0);

    // single-instruction vectors, halted by stop during EXEC
    for (int i = 0; i < 5; i++) begin
      do_reset();
      clear_rom();
      rom[0] = vt[i].ir;
      rom[1] = vt[i].imm;
      q.push_back('{a: 5'd0, d: vt[i].ir});
      pulse_start();
      wait_run(n);
      chk($sformatf("v%0d_lat", i), 32'(n), 32'(vt[i].lat));
      @(negedge clk);
      chk($sformatf("v%0d_exec_din", i), 32'(din), 32'(vt[i].xdin));
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      wait_halt();
      chk($sformatf("v%0d_pc", i), 32'(addr), 32'(vt[i].pc));
      chk($sformatf("v%0d_icount", i), 32'(icount), 32'd1);
    end

    // mvi R0,5 ; add ; then stop/resume around addr 4
    do_reset();
    clear_rom();
    rom[0] = 9'h040;
    rom[1] = 9'h005;
    q.push_back('{a: 5'd0, d: 9'h040});
    q.push_back('{a: 5'd2, d: 9'h000});
    pulse_start();
    wait_run(n);
    @(negedge clk);
    chk("mvi_exec_din", 32'(din), 32'h005);
    wait_run(n);
    stop_halt();
    chk("prog_pc", 32'(addr), 32'd3);
    chk("prog_icount", 32'(icount), 32'd2);
    chk("prog_halted", 32'(halted), 32'd1);

    q.push_back('{a: 5'd3, d: 9'h000});
    q.push_back('{a: 5'd4, d: 9'h000});
    pulse_start();
    wait_run(n);
    @(negedge clk);
    wait_run(n);
    stop_halt();
    chk("stop4_pc", 32'(addr), 32'd5);
    chk("stop4_icount", 32'(icount), 32'd4);
    q.push_back('{a: 5'd5, d: 9'h000});
    pulse_start();
    wait_run(n);
    stop_halt();
    chk("resume5_icount", 32'(icount), 32'd5);

    // mvi at LAST_ADDR takes its immediate from address 0
    do_reset();
    for (int i = 0; i < 31; i++) begin
      rom[i] = {3'b000, 6'(i + 1)};
      q.push_back('{a: 5'(i), d: rom[i]});
    end
    rom[31] = 9'h040;
    q.push_back('{a: 5'd31, d: 9'h040});
    seen31 = 1'b0;
    f0 = 1'b0;
    n = 0;
    pulse_start();
    while (!(run && addr == 5'd31) && n < 400) begin
      @(negedge clk);
      n++;
      if (seen31 && addr == 5'd0 && busy) f0 = 1'b1;
      if (addr == 5'd31) seen31 = 1'b1;
    end
    chk("wrap_run31", 32'(run && addr == 5'd31), 32'd1);
    chk("wrap_fetchd_addr0", 32'(f0), 32'd1);
    @(negedge clk);
    chk("wrap_imm", 32'(din), 32'h001);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_halt();
    chk("wrap_pc", 32'(addr), 32'd1);
    chk("wrap_icount", 32'(icount), 32'd32);

    // watchdog: done never comes
    do_reset();
    clear_rom();
    rom[0] = 9'h00C;
    done_en = 1'b0;
    q.push_back('{a: 5'd0, d: 9'h00C});
    pulse_start();
    wait_run(n);
    n = 0;
    while (!halted && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wd_cycles", 32'(n), 32'd16);
    chk("wd_err", 32'(err), 32'd1);
    chk("wd_halted", 32'(halted), 32'd1);
    chk("wd_pc", 32'(addr), 32'd0);
    chk("wd_icount", 32'(icount), 32'd0);
    done_en = 1'b1;
    q.push_back('{a: 5'd0, d: 9'h00C});
    pulse_start();
    chk("wd_err_clear", 32'(err), 32'd0);
    wait_run(n);
    stop_halt();
    chk("wd_resume_icount", 32'(icount), 32'd1);

    // asynchronous reset in the middle of EXEC
    do_reset();
    clear_rom();
    rom[0] = 9'h011;
    rom[1] = 9'h0C3;
    dly = 6;
    q.push_back('{a: 5'd0, d: 9'h011});
    q.push_back('{a: 5'd1, d: 9'h0C3});
    pulse_start();
    wait_run(n);
    @(negedge clk);
    wait_run(n);
    @(negedge clk);
    chk("rst_pre_din", 32'(din), 32'h0C3);
    #2 resetn = 1'b0;
    #1;
    chk("rst_async",
        32'({run, addr, din, icount, busy}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    dly = 2;
    @(negedge clk);
    chk("rst_idle", 32'({busy, halted}), 32'd0);

    // start and stop together: stop wins
    do_reset();
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("ss_idle_halt", 32'({halted, busy}), 32'b10);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    chk("ss_halt_stay", 32'({halted, busy}), 32'b10);

`ifdef SEQ_STEP_EN
    do_reset();
    clear_rom();
    step_mode = 1'b1;
    q.push_back('{a: 5'd0, d: 9'h000});
    pulse_start();
    wait_run(n);
    repeat (8) @(negedge clk);
    chk("step_pause1", 32'({busy, halted, addr}), 32'd1);
    q.push_back('{a: 5'd1, d: 9'h000});
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_run(n);
    repeat (8) @(negedge clk);
    chk("step_pause2", 32'({busy, halted, addr}), 32'd2);
    chk("step_icount", 32'(icount), 32'd2);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("step_halt", 32'(halted), 32'd1);
    step_mode = 1'b0;
`endif

    chk("sb_drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program sequencer that replaces the free-running address counter and the separate ROM/processor clocks with a single-clock fetch/issue controller. It walks a program counter through the instruction ROM, fetches each instruction plus the immediate word for `mvi`, presents the words on the processor's `Din`, pulses `run`, and waits for `Done` before advancing. It sits between the instruction ROM and the control-unit FSM/datapath pair, and provides start/stop control, an instruction count and a hang watchdog.

## Interface
- `AW`, 5: ROM address width.
- `DW`, 9: instruction/data word width; opcode is `[DW-1:DW-3]`.
- `LAST_ADDR`, 31: highest program address; the PC wraps to 0 after it.
- `ROM_LAT`, 1: ROM read latency in cycles, ≥1.
- `TIMEOUT`, 15: maximum number of EXEC cycles before `err` is raised.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled pulse that begins or resumes execution.
- `stop` in 1: level-sampled pulse that halts after the current instruction.
- `rom_data` in DW: ROM read data.
- `done` in 1: processor `Done`.
- `addr` out AW: ROM address (registered).
- `run` out 1: processor `run` (registered, one-cycle pulse).
- `din` out DW: processor `Din` (registered).
- `busy` out 1: high in any state other than IDLE/HALT.
- `halted` out 1: high in HALT.
- `err` out 1: sticky watchdog flag.
- `icount` out 8: count of completed instructions; wraps 255→0.
- `step_mode`, `step` in 1: present only when `SEQ_STEP_EN` is defined.

## Operation
- States: IDLE, FETCH_I, FETCH_D, ISSUE, EXEC, PAUSE (macro only), HALT.
- Reset value of all outputs and registers is 0; the state resets to IDLE. Reset mid-instruction drops `run` immediately and discards the instruction.
- IDLE: on `start` → FETCH_I. `addr` = `pc` at all times except during FETCH_D.
- FETCH_I: wait ROM_LAT cycles, then latch `rom_data` into `ir_q`. Opcode 3'b001 (`mvi`) → FETCH_D; any other opcode → ISSUE.
- FETCH_D: `addr` = (`pc`==LAST_ADDR ? 0 : `pc`+1). Wait ROM_LAT cycles, latch `imm_q`, → ISSUE.
- ISSUE: one cycle with `run`=1 and `din`=`ir_q`. `done` is ignored in this cycle. → EXEC.
- EXEC: `run`=0; `din`=`imm_q` for `mvi`, otherwise `ir_q`. On `done` sampled high:
  - `pc` += 1, or 2 for `mvi`, modulo LAST_ADDR+1.
  - `icount`++.
  - → HALT if a stop is pending, else FETCH_I.
- Watchdog: if EXEC has lasted TIMEOUT cycles without `done`, set `err`=1, leave `pc` unchanged, → HALT.
- `stop` is captured into `stop_pend` in any busy state and cleared on entry to HALT. `stop` in IDLE moves directly to HALT.
- HALT: on `start`, clear `err` and `stop_pend` and → FETCH_I, resuming at `pc`.
- `start` while busy is ignored. If `start` and `stop` are high in the same cycle in IDLE/HALT, stop wins and the state stays or goes to HALT.
- `mvi` at LAST_ADDR fetches its immediate from address 0 and leaves `pc`=1.

## Timing
- With `start` sampled at edge k:
  - FETCH_I begins at k+1.
  - `run`=1 in the cycle after edge k+1+ROM_LAT for non-`mvi` instructions.
  - `mvi` adds ROM_LAT+1 cycles.
- `done` sampled at edge d in EXEC: FETCH_I begins at d+1, and the next `run` follows ROM_LAT+1 cycles later.
- `din` is stable from the `run` cycle until `done` is sampled. `addr` changes only on state transitions.

## Configuration
- `SEQ_STEP_EN` defined: adds the `step_mode` and `step` ports.
  - With `step_mode`=1, completion of an instruction goes to PAUSE instead of FETCH_I.
  - In PAUSE, `step` → FETCH_I and `stop` → HALT.
  - PAUSE drives `busy`=0.
- `SEQ_STEP_EN` undefined: no PAUSE state and no step ports; behaviour is identical to the macro-defined build with `step_mode`=0.

## Test plan
- ROM {0: mvi R0, 1: 9'd5, 2: add R0,R0} with a model FSM `done` 2 cycles after `run` → `run` pulses at addr 0 then 2, `din`=9'd5 during the first EXEC, `pc`=3, `icount`=2.
- `mvi` at addr 31 (immediate at addr 0) → FETCH_D drives `addr`=0, then `pc`=1 after completion.
- `stop` pulsed during EXEC of the instruction at addr 4 → that instruction completes, `halted`=1, `pc`=5; `start` resumes with `addr`=5.
- `done` never asserted → `err`=1 after 15 EXEC cycles, `halted`=1, `pc` unchanged; `start` clears `err`.
- `resetn` low during EXEC → `run`, `addr`, `din`, `icount` = 0 immediately; the state is IDLE after release.
- `SEQ_STEP_EN` build, `step_mode`=1 → stays in PAUSE after each instruction; each `step` pulse yields exactly one `run` pulse.
